// File: rtl/usb_rst_sequencer.sv
// Avalon-MM reset sequencer for the USB controller chip: it generates a timed assert
// phase followed by a settle phase, and also provides power-on auto start, a manual hold and a done interrupt.
module usb_rst_sequencer #(
  parameter int unsigned ASSERT_CYCLES = 500,
  parameter int unsigned SETTLE_CYCLES = 5000,
  parameter int unsigned CNT_W         = 16,
  parameter bit          AUTO_START    = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        usb_rst_n,
  output logic        busy,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_SETTLE
  } state_e;

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] ASSERT_RST = CNT_W'(ASSERT_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_RST = CNT_W'(SETTLE_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] assert_len_q, assert_len_d;
  logic [CNT_W-1:0] settle_len_q, settle_len_d;
  logic             hold_q, hold_d;
  logic             irq_en_q, irq_en_d;
  logic             done_q, done_d;
  logic             usb_rst_n_q, usb_rst_n_d;

  logic             wr_en;
  logic             ctrl_wr;
  logic             stat_wr;
  logic             alen_wr;
  logic             slen_wr;
  logic             abort;
  logic [CNT_W-1:0] assert_load;
  logic [CNT_W-1:0] settle_load;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  assign wr_en   = chipselect & ~write_n;
  assign ctrl_wr = wr_en & (address == 2'd0);
  assign stat_wr = wr_en & (address == 2'd1);
  assign alen_wr = wr_en & (address == 2'd2);
  assign slen_wr = wr_en & (address == 2'd3);
  assign abort   = ctrl_wr & writedata[1];

  // A programmed length of zero behaves like one, so the counter never underflows.
  assign assert_load = (assert_len_q == '0) ? '0 : assert_len_q - ONE;
  assign settle_load = (settle_len_q == '0) ? '0 : settle_len_q - ONE;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    assert_len_d = assert_len_q;
    settle_len_d = settle_len_q;
    hold_d       = hold_q;
    irq_en_d     = irq_en_q;
    done_d       = done_q;
    usb_rst_n_d  = usb_rst_n_q;

    if (ctrl_wr) begin
      hold_d   = writedata[1];
      irq_en_d = writedata[2];
    end
    if (stat_wr && writedata[1]) begin
      done_d = 1'b0;
    end
    if (alen_wr && (state_q == ST_IDLE)) begin
      assert_len_d = writedata[CNT_W-1:0];
    end
    if (slen_wr && (state_q == ST_IDLE)) begin
      settle_len_d = writedata[CNT_W-1:0];
    end

    // A hold request beats both a start and the natural end of a sequence.
    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_wr && writedata[0] && !writedata[1] && !hold_q) begin
          state_d = ST_ASSERT;
          cnt_d   = assert_load;
          done_d  = 1'b0;
        end
      end
      ST_ASSERT: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          cnt_d   = settle_load;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    unique case (state_d)
      ST_ASSERT: usb_rst_n_d = 1'b0;
      ST_SETTLE: usb_rst_n_d = 1'b1;
      default:   usb_rst_n_d = ~hold_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      assert_len_q <= ASSERT_RST;
      settle_len_q <= SETTLE_RST;
      hold_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      usb_rst_n_q  <= 1'b0;
      if (AUTO_START) begin
        state_q <= ST_ASSERT;
        cnt_q   <= ASSERT_RST - ONE;
      end else begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      assert_len_q <= assert_len_d;
      settle_len_q <= settle_len_d;
      hold_q       <= hold_d;
      irq_en_q     <= irq_en_d;
      done_q       <= done_d;
      usb_rst_n_q  <= usb_rst_n_d;
    end
  end

  assign usb_rst_n = usb_rst_n_q;
  assign busy      = (state_q != ST_IDLE);
  assign irq       = done_q & irq_en_q;

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0:    readdata = {29'b0, irq_en_q, hold_q, 1'b0};
      2'd1:    readdata = {29'b0, usb_rst_n_q, done_q, busy};
      2'd2:    readdata = 32'(assert_len_q);
      default: readdata = 32'(settle_len_q);
    endcase
  end

endmodule

// File: tb/tb_usb_rst_sequencer.sv
// Bench for usb_rst_sequencer: a sequence-timeline reference model is checked every cycle,
// together with directed scenarios that pin literal expectations.
module tb_usb_rst_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd1;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        usb_rst_n;
  logic        busy;
  logic        irq;

  int checks = 0;
  int errors = 0;

  usb_rst_sequencer #(
    .ASSERT_CYCLES(4),
    .SETTLE_CYCLES(6),
    .CNT_W(16),
    .AUTO_START(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .usb_rst_n(usb_rst_n),
    .busy(busy),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // The model describes a sequence as a timeline: elapsed cycles since start plus total lengths.
  bit m_valid = 1'b0;
  bit m_in_seq, m_hold, m_irq_en, m_done;
  int m_pos, m_la, m_ls, m_alen, m_slen;

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  always @(posedge clk) begin : model_update
    bit wr, was_busy, ending, abort_req, start_ok;
    if (!reset_n) begin
      m_valid  = 1'b1;
      m_in_seq = 1'b1;
      m_pos    = 0;
      m_la     = 4;
      m_ls     = 6;
      m_alen   = 4;
      m_slen   = 6;
      m_hold   = 1'b0;
      m_irq_en = 1'b0;
      m_done   = 1'b0;
    end else begin
      wr        = chipselect && !write_n;
      was_busy  = m_in_seq;
      ending    = m_in_seq && (m_pos + 1 == m_la + m_ls);
      abort_req = m_in_seq && wr && (address == 2'd0) && writedata[1];
      start_ok  = !m_in_seq && wr && (address == 2'd0) && writedata[0]
                  && !writedata[1] && !m_hold;
      if (wr && (address == 2'd1) && writedata[1]) m_done = 1'b0;
      if (ending && !abort_req) m_done = 1'b1;
      if (m_in_seq) begin
        m_pos = m_pos + 1;
        if (ending || abort_req) m_in_seq = 1'b0;
      end
      if (start_ok) begin
        m_in_seq = 1'b1;
        m_pos    = 0;
        m_la     = max1(m_alen);
        m_ls     = max1(m_slen);
        m_done   = 1'b0;
      end
      if (wr && (address == 2'd0)) begin
        m_hold   = writedata[1];
        m_irq_en = writedata[2];
      end
      if (wr && !was_busy && (address == 2'd2)) m_alen = int'(writedata[15:0]);
      if (wr && !was_busy && (address == 2'd3)) m_slen = int'(writedata[15:0]);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    bit exp_rst;
    logic [31:0] exp_rd;
    if (m_valid) begin
      exp_rst = m_in_seq ? (m_pos >= m_la) : !m_hold;
      case (address)
        2'd0:    exp_rd = {29'b0, m_irq_en, m_hold, 1'b0};
        2'd1:    exp_rd = {29'b0, exp_rst, m_done, m_in_seq};
        2'd2:    exp_rd = 32'(m_alen);
        default: exp_rd = 32'(m_slen);
      endcase
      check("model usb_rst_n", 32'(usb_rst_n), 32'(exp_rst));
      check("model busy", 32'(busy), 32'(m_in_seq));
      check("model irq", 32'(irq), 32'(m_done && m_irq_en));
      check("model readdata", readdata, exp_rd);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
  endtask

  task automatic release_bus();
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd1;
    writedata  = '0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    drive_write(a, d);
    next_cycle();
    release_bus();
  endtask

  initial begin : stimulus
    logic [31:0] d;
    int r;

    // Power-on auto sequence: 4 cycles asserted, 6 settling, done on cycle 11.
    repeat (3) next_cycle();
    reset_n = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k <= 10) begin
        check("auto busy", 32'(busy), 32'd1);
        check("auto usb_rst_n", 32'(usb_rst_n), (k <= 4) ? 32'd0 : 32'd1);
      end else begin
        check("auto end busy", 32'(busy), 32'd0);
        check("auto end status", readdata, 32'h6);
      end
    end
    next_cycle();

    // Short sequence with a zero settle length and interrupt enabled.
    bus_write(2'd2, 32'd2);
    bus_write(2'd3, 32'd0);
    bus_write(2'd0, 32'h4);
    bus_write(2'd0, 32'h5);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k <= 2) check("short usb_rst_n low", 32'(usb_rst_n), 32'd0);
      if (k == 3) check("short settle busy", 32'(busy), 32'd1);
      if (k == 3) check("short settle rst", 32'(usb_rst_n), 32'd1);
      if (k == 4) check("short end busy", 32'(busy), 32'd0);
      if (k == 4) check("short irq", 32'(irq), 32'd1);
    end
    next_cycle();
    bus_write(2'd1, 32'h2);
    @(negedge clk);
    check("w1c irq", 32'(irq), 32'd0);
    check("w1c status", readdata, 32'h4);

    // Start during ASSERT and a length write during SETTLE change nothing.
    next_cycle();
    bus_write(2'd3, 32'd3);
    bus_write(2'd0, 32'h5);
    drive_write(2'd0, 32'h5);
    next_cycle();
    release_bus();
    next_cycle();
    drive_write(2'd2, 32'd9);
    next_cycle();
    release_bus();
    address = 2'd2;
    @(negedge clk);
    check("dropped alen", readdata, 32'd2);
    next_cycle();
    next_cycle();
    address = 2'd1;
    @(negedge clk);
    check("unchanged timing status", readdata, 32'h6);

    // Done set and W1C on the same edge: set wins.
    next_cycle();
    bus_write(2'd0, 32'h5);
    repeat (4) next_cycle();
    drive_write(2'd1, 32'h2);
    next_cycle();
    release_bus();
    @(negedge clk);
    check("set beats w1c", readdata, 32'h6);
    check("set beats w1c irq", 32'(irq), 32'd1);

    // Hold mid-SETTLE aborts; start with hold set is ignored; clearing hold releases the chip.
    next_cycle();
    bus_write(2'd3, 32'd6);
    bus_write(2'd0, 32'h5);
    repeat (2) next_cycle();
    drive_write(2'd0, 32'h6);
    next_cycle();
    release_bus();
    @(negedge clk);
    check("abort status", readdata, 32'h0);
    check("abort busy", 32'(busy), 32'd0);
    next_cycle();
    bus_write(2'd0, 32'h5);
    @(negedge clk);
    check("start under hold busy", 32'(busy), 32'd0);
    next_cycle();
    bus_write(2'd0, 32'h4);
    @(negedge clk);
    check("hold cleared usb_rst_n", 32'(usb_rst_n), 32'd1);

    // Reset pulse mid-SETTLE restores defaults and restarts the auto sequence.
    next_cycle();
    bus_write(2'd0, 32'h5);
    repeat (3) next_cycle();
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    address = 2'd2;
    @(negedge clk);
    check("reset usb_rst_n", 32'(usb_rst_n), 32'd0);
    check("reset busy", 32'(busy), 32'd1);
    check("reset alen", readdata, 32'd4);
    next_cycle();
    address = 2'd3;
    @(negedge clk);
    check("reset slen", readdata, 32'd6);
    next_cycle();
    address = 2'd0;
    @(negedge clk);
    check("reset ctrl", readdata, 32'h0);
    next_cycle();
    address = 2'd1;

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 199));
      if (r < 1) begin
        release_bus();
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
      end else if (r < 30) begin
        address = 2'($urandom_range(0, 3));
        case (address)
          2'd0: begin
            d = '0;
            d[0] = 1'($urandom_range(0, 1));
            d[1] = ($urandom_range(0, 7) == 0);
            d[2] = 1'($urandom_range(0, 1));
          end
          2'd1:    d = $urandom;
          default: d = 32'($urandom_range(0, 5));
        endcase
        drive_write(address, d);
        next_cycle();
        release_bus();
      end else begin
        address = 2'($urandom_range(0, 3));
        next_cycle();
      end
    end
    release_bus();
    repeat (20) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
